fifo_rd_arb: RTL and testbench
==============================

# fifo_rd_arb

Round-robin read-port arbiter for the asynchronous FIFO, in the read clock domain. It shares the FIFO read port (`rempty`/`rinc`/`rdata`) among `NREQ` consumers and grants one consumer at a time for a bounded burst of pops. Popped words are registered and returned with a one-hot valid to the owning consumer. It sits downstream of the read-side pointer synchroniser and empty-flag logic, and drives `rinc` directly.

## Interface
- `DSIZE`, default 8: FIFO data width.
- `NREQ`, default 4: number of consumers; legal range 2..8.
- `BURST`, default 4: maximum pops per grant; must be ≥1.
- `i_clk`, in, 1: read-domain clock; all logic on its rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_req`, in, `NREQ`: per-consumer read request, level-sensitive.
- `i_rempty`, in, 1: FIFO empty flag, synchronous to `i_clk`.
- `i_rdata`, in, `DSIZE`: FIFO head word; valid whenever `i_rempty`=0.
- `o_rinc`, out, 1: FIFO pop strobe; combinational from registered state and inputs.
- `o_gnt`, out, `NREQ`: registered one-hot grant; all zero when idle.
- `o_data`, out, `DSIZE`: registered popped word.
- `o_valid`, out, `NREQ`: registered one-hot; bit k marks `o_data` as belonging to consumer k.

## Operation
- FSM has two states, IDLE and GRANT. Internal registers:
  - `owner`: index of the granted consumer.
  - `last`: index of the last granted consumer.
  - `cnt`: pop count, width clog2(BURST+1).
- **Reset values**:
  - Outputs: `o_gnt`=0, `o_valid`=0, `o_data`=0.
  - Internal: state=IDLE, `cnt`=0, `last`=NREQ-1, so consumer 0 has first priority.
- **IDLE**:
  - `o_rinc`=0.
  - If `|i_req` and `!i_rempty`, pick the first requesting index scanning from `last+1` upward, modulo NREQ.
  - Set `owner`=`last`=that index and `o_gnt`=one-hot(`owner`), clear `cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**:
  - `o_rinc` = `i_req[owner] & !i_rempty`.
  - On a pop: `cnt` increments, `o_data` takes `i_rdata`, and `o_valid` takes one-hot(`owner`) on the next edge.
  - `o_valid` is zero in any cycle following a non-pop cycle.
- **Leave GRANT for IDLE** (clearing `o_gnt`) at the edge where any of these holds:
  - a pop makes `cnt` reach BURST;
  - `i_req[owner]`=0;
  - `i_rempty`=1.
- These release conditions are evaluated together. A pop that hits BURST in the same cycle as a request drop still counts as one pop plus a release.
- **Rearbitration**:
  - After release, IDLE always spends one cycle before the next grant. No back-to-back grant edge.
  - The same consumer may be regranted if it is the only requester. Rotation from `last` guarantees fairness.
- **FIFO rules**:
  - `o_rinc` is never asserted while `i_rempty`=1. No underflow pop, including when `i_rempty` rises in the same cycle.
  - `o_rinc` is never asserted in IDLE.
- **Reset mid-burst**: `o_rinc` drops immediately (asynchronously) because state becomes IDLE. All registers return to reset values. Any word in flight in `o_data` is discarded.
- **Request handshake**:
  - Requests from non-owners are ignored during GRANT.
  - A consumer must hold `i_req` until it sees `o_gnt`. Dropping earlier simply forfeits arbitration.

## Timing
- Grant latency: a request seen in IDLE produces `o_gnt` on the next edge. The first pop can occur in that same GRANT cycle.
- Data latency: `o_data`/`o_valid` appear exactly one cycle after the `o_rinc` cycle.
- Maximum throughput is 1 word per cycle within a burst. A full BURST grant costs BURST+1 cycles including the idle gap.
- `o_rinc` combinational path: `i_req`, `i_rempty` → `o_rinc`. It must close within one read-clock period together with FIFO pointer increment logic.

## Test plan
- **Reset**: assert `i_rst` mid-cycle during a burst.
  - `o_rinc` drops immediately; `o_gnt`, `o_valid` and `o_data` read 0.
  - After release, first grant goes to consumer 0 if requesting.
- **Round robin**: FIFO holds 10 words, `i_req`=4'b0101, BURST=4.
  - Edge 1: `o_gnt`=0001; `o_rinc` high for 4 cycles; `o_valid`=0001 for words 0–3.
  - One idle cycle, then `o_gnt`=0100 and words 4–7 go to consumer 2.
  - Then consumer 0 gets words 8–9 and releases on empty.
- **Empty stall**: FIFO holds 2 words; consumer 1 requests. Exactly 2 pops, `i_rempty` rises, grant releases, and there is no pop while empty.
- **Request drop**: consumer 3 drops `i_req` after 2 pops with BURST=4. Release on that edge; only 2 `o_valid`=1000 pulses.
- **Simultaneous release**: BURST=1 with one requester and a 3-word FIFO.
  - Pattern is grant/pop/idle repeated 3 times; `o_valid` is pulsed 3 times.
  - `cnt` never exceeds 1.
- **Empty race**: `i_rempty` rises in the same cycle `i_req[owner]` falls. Check `o_rinc`=0 in that cycle and a single release to IDLE.

Source files
------------

// File: rtl/fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_arb
// Brief   : Round-robin, burst-limited arbiter sharing the async FIFO read port.
// Revision: 1.0
// ============================================================================
module fifo_rd_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_rempty,
    input  logic [DSIZE-1:0] i_rdata,
    output logic             o_rinc,
    output logic [NREQ-1:0]  o_gnt,
    output logic [DSIZE-1:0] o_data,
    output logic [NREQ-1:0]  o_valid
);

    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              CW       = (BURST > 0) ? $clog2(BURST + 1) : 1;
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [CW-1:0]   BURST_C  = CW'(BURST);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          pop;
    logic          rel;
    logic          start;

    assign cnt_inc = cnt + 1'b1;

    // Rotating priority: first requester strictly after the last winner.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (!found && i_req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All release causes are OR-ed so a BURST-hitting pop and an empty/drop
    // release collapse into a single return to IDLE.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rel       = 1'b0;
        start     = 1'b0;
        o_rinc    = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req && !i_rempty) begin
                    start     = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                pop = i_req[owner] & ~i_rempty;
                rel = (pop && (cnt_inc == BURST_C)) || !i_req[owner] || i_rempty;
                if (rel) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        o_rinc = pop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner   <= '0;
            last    <= LAST_RST;
            cnt     <= '0;
            o_gnt   <= '0;
            o_valid <= '0;
            o_data  <= '0;
        end else begin
            o_valid <= pop ? (ONE << owner) : '0;
            if (pop) begin
                o_data <= i_rdata;
                cnt    <= cnt_inc;
            end
            if (start) begin
                owner <= pick;
                last  <= pick;
                cnt   <= '0;
                o_gnt <= ONE << pick;
            end else if (rel) begin
                o_gnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_arb
// Brief   : Vector-table and scoreboard bench for fifo_rd_arb (BURST=4 and 1).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rd_arb;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NREQ-1:0]  req_a, req_b;
    logic             rempty_a, rempty_b;
    logic [DSIZE-1:0] rdata_a, rdata_b;
    logic             rinc_a, rinc_b;
    logic [NREQ-1:0]  gnt_a, gnt_b, valid_a, valid_b;
    logic [DSIZE-1:0] data_a, data_b;

    fifo_rd_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_rempty(rempty_a),
        .i_rdata(rdata_a), .o_rinc(rinc_a), .o_gnt(gnt_a), .o_data(data_a),
        .o_valid(valid_a)
    );

    fifo_rd_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_rempty(rempty_b),
        .i_rdata(rdata_b), .o_rinc(rinc_b), .o_gnt(gnt_b), .o_data(data_b),
        .o_valid(valid_b)
    );

    typedef struct {
        bit               sel;     // 0: BURST=4 instance, 1: BURST=1 instance
        logic [NREQ-1:0]  req;
        logic             rempty;
        logic [DSIZE-1:0] rdata;
        logic [NREQ-1:0]  gnt;
        logic             rinc;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0]  valid;
        logic [DSIZE-1:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input bit sel, input logic [NREQ-1:0] req, input logic rempty,
                                input logic [DSIZE-1:0] rdata, input logic [NREQ-1:0] gnt,
                                input logic rinc);
        vec_t v;
        v.sel = sel; v.req = req; v.rempty = rempty; v.rdata = rdata;
        v.gnt = gnt; v.rinc = rinc;
        vecs.push_back(v);
    endfunction

    task automatic run_row(input vec_t v, input int n);
        exp_t            e;
        logic [NREQ-1:0] g, vl;
        logic [DSIZE-1:0] d;
        logic            r;
        req_a    = v.sel ? '0 : v.req;
        rempty_a = v.sel ? 1'b1 : v.rempty;
        rdata_a  = v.rdata;
        req_b    = v.sel ? v.req : '0;
        rempty_b = v.sel ? v.rempty : 1'b1;
        rdata_b  = v.rdata;
        @(negedge clk);
        g  = v.sel ? gnt_b   : gnt_a;
        r  = v.sel ? rinc_b  : rinc_a;
        vl = v.sel ? valid_b : valid_a;
        d  = v.sel ? data_b  : data_a;
        chk($sformatf("row%0d gnt", n), 32'(g), 32'(v.gnt));
        chk($sformatf("row%0d rinc", n), 32'(r), 32'(v.rinc));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("row%0d valid", n), 32'(vl), 32'(e.valid));
            chk($sformatf("row%0d data", n), 32'(d), 32'(e.data));
        end else begin
            chk($sformatf("row%0d valid_idle", n), 32'(vl), 32'(0));
        end
        if (v.rinc) begin
            e.valid = v.gnt;
            e.data  = v.rdata;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round robin: 10 words A0..A9, consumers 0 and 2 requesting.
        add(0, 4'b0101, 0, 8'hA0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0101, 0, 8'(8'hA0 + i), 4'b0001, 1);
        add(0, 4'b0101, 0, 8'hA4, 4'b0000, 0);
        for (int i = 4; i < 8; i++) add(0, 4'b0101, 0, 8'(8'hA0 + i), 4'b0100, 1);
        add(0, 4'b0101, 0, 8'hA8, 4'b0000, 0);
        add(0, 4'b0101, 0, 8'hA8, 4'b0001, 1);
        add(0, 4'b0101, 0, 8'hA9, 4'b0001, 1);
        add(0, 4'b0101, 1, 8'h00, 4'b0001, 0);
        add(0, 4'b0101, 1, 8'h00, 4'b0000, 0);
        add(0, 4'b0000, 1, 8'h00, 4'b0000, 0);
        // Empty stall: consumer 1, two words.
        add(0, 4'b0010, 0, 8'hB0, 4'b0000, 0);
        add(0, 4'b0010, 0, 8'hB0, 4'b0010, 1);
        add(0, 4'b0010, 0, 8'hB1, 4'b0010, 1);
        add(0, 4'b0010, 1, 8'h00, 4'b0010, 0);
        add(0, 4'b0010, 1, 8'h00, 4'b0000, 0);
        add(0, 4'b0000, 1, 8'h00, 4'b0000, 0);
        // Request drop: consumer 3 leaves after two pops.
        add(0, 4'b1000, 0, 8'hC0, 4'b0000, 0);
        add(0, 4'b1000, 0, 8'hC0, 4'b1000, 1);
        add(0, 4'b1000, 0, 8'hC1, 4'b1000, 1);
        add(0, 4'b0000, 0, 8'hC2, 4'b1000, 0);
        add(0, 4'b0000, 0, 8'hC2, 4'b0000, 0);
        // Empty race: request falls as FIFO empties.
        add(0, 4'b0001, 0, 8'hD0, 4'b0000, 0);
        add(0, 4'b0001, 0, 8'hD0, 4'b0001, 1);
        add(0, 4'b0000, 1, 8'h00, 4'b0001, 0);
        add(0, 4'b0000, 0, 8'hD1, 4'b0000, 0);
        add(0, 4'b0000, 0, 8'hD1, 4'b0000, 0);
        // BURST=1, single requester, three words: grant/pop/idle x3.
        add(1, 4'b0100, 0, 8'hE0, 4'b0000, 0);
        add(1, 4'b0100, 0, 8'hE0, 4'b0100, 1);
        add(1, 4'b0100, 0, 8'hE1, 4'b0000, 0);
        add(1, 4'b0100, 0, 8'hE1, 4'b0100, 1);
        add(1, 4'b0100, 0, 8'hE2, 4'b0000, 0);
        add(1, 4'b0100, 0, 8'hE2, 4'b0100, 1);
        add(1, 4'b0100, 1, 8'h00, 4'b0000, 0);
        add(1, 4'b0000, 1, 8'h00, 4'b0000, 0);

        rst = 1'b0;
        req_a = '0; req_b = '0; rempty_a = 1'b1; rempty_b = 1'b1;
        rdata_a = '0; rdata_b = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst gnt", 32'(gnt_a), 32'(0));
        chk("rst valid", 32'(valid_a), 32'(0));
        chk("rst data", 32'(data_a), 32'(0));
        chk("rst rinc", 32'(rinc_a), 32'(0));
        chk("rst gnt_b1", 32'(gnt_b), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

        // Asynchronous reset in the middle of a burst.
        req_a = 4'b0001; rempty_a = 1'b0; rdata_a = 8'h55;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("mid rinc_before", 32'(rinc_a), 32'(1));
        chk("mid data_before", 32'(data_a), 32'h55);
        rst = 1'b1;
        #1;
        chk("mid rinc", 32'(rinc_a), 32'(0));
        chk("mid gnt", 32'(gnt_a), 32'(0));
        chk("mid valid", 32'(valid_a), 32'(0));
        chk("mid data", 32'(data_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        req_a = 4'b1111;
        @(posedge clk); #1;
        chk("post_rst gnt", 32'(gnt_a), 32'b0001);
        chk("post_rst rinc", 32'(rinc_a), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
